fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
Controls the IF stage of the pipelined RV32I core. It owns the instruction-memory request/acknowledge handshake and drives the PC-register enable. It also holds one fetched instruction across decode stalls and discards stale responses after an execute-stage redirect. It sits between the fetch datapath (PC generator) and the IF/ID register, which it feeds with a registered instruction, PC and valid bit.

Parameters:
WIDTH, 32, address/instruction width
BOOT_CYCLES, 2, idle cycles after reset release before the first request (1..15)
TIMEOUT, 64, cycles a request may wait for ack before the sticky error is set (2..255)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
pc_f  input  WIDTH  current PC from fetch datapath
redirect_e  input  1  execute-stage branch/jump taken (PCSrcE != 0)
stall_d  input  1  decode stall (load-use); IF/ID must hold
pc_en  output  1  enable to PC register
flush_d  output  1  flush IF/ID (combinational, equals redirect_e)
imem_req  output  1  instruction-memory request
imem_addr  output  WIDTH  request address
imem_ack  input  1  response valid, one cycle per request, rdata valid same cycle
imem_rdata  input  WIDTH  instruction word
instr_f  output  WIDTH  registered instruction to IF/ID
instr_pc_f  output  WIDTH  PC of instr_f
instr_valid_f  output  1  instr_f valid
fetch_err  output  1  sticky ack-timeout flag

Behaviour:
- States: BOOT, REQ, HOLD, DRAIN. Reset (rst high) forces BOOT, boot counter 0, instr_f/instr_pc_f/instr_valid_f/fetch_err 0, skid buffer empty, wait counter 0.
- While rst is high, pc_en=1 so the PC register loads the reset vector 0. imem_req=0.
- BOOT: pc_en=0, imem_req=0. Lasts exactly BOOT_CYCLES cycles after rst falls, then REQ.
- REQ: imem_req=1, imem_addr=pc_f (combinational), and req_addr_q<=pc_f. On each cycle:
  - ack & redirect_e: drop rdata, pc_en=1, stay REQ.
  - ack & stall_d (no redirect): rdata and pc_f go to the skid buffer, pc_en=0, go to HOLD.
  - ack otherwise: instr_f<=rdata, instr_pc_f<=pc_f, valid<=1, pc_en=1, stay REQ. Zero-wait memory therefore gives one instruction per cycle.
  - no ack & redirect_e: pc_en=1, go to DRAIN.
  - no ack otherwise: pc_en=0, stay REQ.
- HOLD: imem_req=0.
  - redirect_e: buffer discarded, pc_en=1, go to REQ.
  - else !stall_d: instr_f/instr_pc_f<=buffer, valid<=1, pc_en=1, go to REQ.
  - else stay in HOLD with pc_en=0.
- DRAIN: imem_req=1, imem_addr=req_addr_q (the outstanding old address is held until ack). pc_en=0 unless redirect_e.
  - On ack: response dropped, go to REQ.
  - A further redirect_e in DRAIN pulses pc_en again; the state stays DRAIN.
- redirect_e has priority over stall_d and ack in every state. flush_d=redirect_e in all states except BOOT and rst.
- IF/ID output register:
  - redirect_e: valid<=0 next cycle.
  - stall_d (no redirect): instr_f/instr_pc_f/valid hold.
  - otherwise, with no delivery this cycle: valid<=0.
- imem_ack in BOOT or HOLD is a protocol error and is ignored.
- Timeout: the wait counter increments each cycle imem_req=1 and imem_ack=0, and clears on ack. When it reaches TIMEOUT, fetch_err<=1, held until rst. The counter saturates; the handshake continues.
- rst asserted mid-request (any state) returns to BOOT next cycle. A late ack arriving during BOOT is ignored.

Test Plan:
- Reset, BOOT_CYCLES=2, zero-wait memory: pc_en low for 2 cycles after rst falls, then imem_addr=0,4,8 on consecutive cycles. instr_valid_f=1 from the cycle after the first ack, with instr_pc_f=0,4,8.
- 3-cycle memory latency: imem_req held 3 cycles at 0x10, pc_en pulses once on the ack cycle, instr_f=rdata next cycle. No duplicate or missing instruction.
- stall_d high 2 cycles coincident with ack at PC 0x20: state HOLD, outputs frozen, imem_req=0. On stall release instr_pc_f=0x20 and pc_en=1, then fetching resumes at 0x24.
- redirect_e while waiting on 0x30 (latency 4): flush_d=1, pc_en=1, DRAIN keeps imem_addr=0x30 until ack. That response is dropped (valid stays 0), then a request is issued to the target PC.
- redirect_e same cycle as ack and stall_d: rdata dropped, no HOLD entry, flush_d=1, valid=0 next cycle.
- ack never returns, TIMEOUT=8: fetch_err rises after 8 waiting cycles, stays set, and clears only on rst.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: IF-stage controller for the pipelined RV32I core.
// Owns the instruction-memory request/ack handshake and drives the PC enable.
// Holds one fetched word while decode stalls, and drops stale responses after
// an execute-stage redirect. Feeds IF/ID with a registered instruction, PC and valid.
module fetch_sequencer #(
  parameter int WIDTH       = 32,
  parameter int BOOT_CYCLES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_f,
  input  logic             redirect_e,
  input  logic             stall_d,
  output logic             pc_en,
  output logic             flush_d,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr_f,
  output logic [WIDTH-1:0] instr_pc_f,
  output logic             instr_valid_f,
  output logic             fetch_err
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);
  localparam logic [7:0] WAIT_MAX  = 8'(TIMEOUT);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       boot_cnt_q, boot_cnt_d;
  logic [WIDTH-1:0] req_addr_q, req_addr_d;
  logic [WIDTH-1:0] skid_instr_q, skid_instr_d;
  logic [WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic             valid_q, valid_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;

  logic             deliver;
  logic [WIDTH-1:0] deliver_instr;
  logic [WIDTH-1:0] deliver_pc;

  // Sequencer next-state, handshake outputs, IF/ID update and ack-timeout tracking.
  always_comb begin
    state_d       = state_q;
    boot_cnt_d    = boot_cnt_q;
    req_addr_d    = req_addr_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    skid_valid_d  = skid_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    valid_d       = valid_q;
    wait_cnt_d    = wait_cnt_q;
    err_d         = err_q;
    pc_en         = 1'b0;
    flush_d       = 1'b0;
    imem_req      = 1'b0;
    imem_addr     = pc_f;
    deliver       = 1'b0;
    deliver_instr = imem_rdata;
    deliver_pc    = pc_f;

    if (rst) begin
      // PC register loads the reset vector while reset is held.
      pc_en = 1'b1;
    end else begin
      case (state_q)
        S_BOOT: begin
          if (boot_cnt_q == BOOT_LAST) begin
            boot_cnt_d = 4'd0;
            state_d    = S_REQ;
          end else begin
            boot_cnt_d = boot_cnt_q + 4'd1;
          end
        end

        S_REQ: begin
          imem_req   = 1'b1;
          imem_addr  = pc_f;
          req_addr_d = pc_f;
          flush_d    = redirect_e;
          if (imem_ack) begin
            if (redirect_e) begin
              pc_en = 1'b1;
            end else if (stall_d) begin
              skid_instr_d = imem_rdata;
              skid_pc_d    = pc_f;
              skid_valid_d = 1'b1;
              state_d      = S_HOLD;
            end else begin
              deliver = 1'b1;
              pc_en   = 1'b1;
            end
          end else if (redirect_e) begin
            pc_en   = 1'b1;
            state_d = S_DRAIN;
          end
        end

        S_HOLD: begin
          flush_d = redirect_e;
          if (redirect_e) begin
            skid_valid_d = 1'b0;
            pc_en        = 1'b1;
            state_d      = S_REQ;
          end else if (!stall_d) begin
            deliver       = 1'b1;
            deliver_instr = skid_instr_q;
            deliver_pc    = skid_pc_q;
            skid_valid_d  = 1'b0;
            pc_en         = 1'b1;
            state_d       = S_REQ;
          end
        end

        default: begin
          imem_req  = 1'b1;
          imem_addr = req_addr_q;
          flush_d   = redirect_e;
          pc_en     = redirect_e;
          if (imem_ack) begin
            state_d = S_REQ;
          end
        end
      endcase

      if (deliver) begin
        instr_d    = deliver_instr;
        instr_pc_d = deliver_pc;
        valid_d    = 1'b1;
      end else if (redirect_e) begin
        valid_d = 1'b0;
      end else if (!stall_d) begin
        valid_d = 1'b0;
      end

      if (imem_req) begin
        if (imem_ack) begin
          wait_cnt_d = 8'd0;
        end else begin
          if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
          if (wait_cnt_q >= WAIT_LAST) begin
            err_d = 1'b1;
          end
        end
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_BOOT;
      boot_cnt_q   <= 4'd0;
      req_addr_q   <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_valid_q <= 1'b0;
      instr_q      <= '0;
      instr_pc_q   <= '0;
      valid_q      <= 1'b0;
      wait_cnt_q   <= 8'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      boot_cnt_q   <= boot_cnt_d;
      req_addr_q   <= req_addr_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_valid_q <= skid_valid_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      valid_q      <= valid_d;
      wait_cnt_q   <= wait_cnt_d;
      err_q        <= err_d;
    end
  end

  assign instr_f       = instr_q;
  assign instr_pc_f    = instr_pc_q;
  assign instr_valid_f = valid_q;
  assign fetch_err     = err_q;

endmodule
